// File: rtl/hilo_muldiv_pkg.sv
// Shared encodings for the HI/LO write-port producer:
// opcodes, FSM states, write-enable bits and divider depth.
package hilo_muldiv_pkg;

    localparam int DIV_CYCLES = 32;

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    // Bit order matches the HI/LO register port {hi_we, lo_we}.
    localparam logic [1:0] WE_HI = 2'b10;
    localparam logic [1:0] WE_LO = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_DIV  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    function automatic logic [31:0] mag32(input logic [31:0] x,
                                          input logic        is_signed);
        return (is_signed && x[31]) ? (~x + 32'd1) : x;
    endfunction

endpackage

// File: rtl/div_radix2_iter.sv
// Unsigned 32-bit radix-2 restoring divider core.
// One quotient bit per clock, MSB first.
module div_radix2_iter
    import hilo_muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic        i_cancel,
    input  logic [31:0] i_dividend,
    input  logic [31:0] i_divisor,
    output logic        o_done,
    output logic [31:0] o_quotient,
    output logic [31:0] o_remainder
);

    logic [31:0] r_rem;
    logic [31:0] r_quo;
    logic [31:0] r_div;
    logic [5:0]  r_cnt;
    logic        r_act;

    logic [32:0] w_rem_sh;
    logic [33:0] w_diff;
    logic        w_fits;

    assign w_rem_sh = {r_rem, r_quo[31]};
    assign w_diff   = {1'b0, w_rem_sh} - {2'b00, r_div};
    assign w_fits   = ~w_diff[33];

    // High while the final bit is being produced; result valid after this edge.
    assign o_done      = r_act && (r_cnt == 6'(DIV_CYCLES - 1));
    assign o_quotient  = r_quo;
    assign o_remainder = r_rem;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem <= '0;
            r_quo <= '0;
            r_div <= '0;
            r_cnt <= '0;
            r_act <= 1'b0;
        end else if (i_start) begin
            r_rem <= '0;
            r_quo <= i_dividend;
            r_div <= i_divisor;
            r_cnt <= '0;
            r_act <= 1'b1;
        end else if (i_cancel) begin
            r_act <= 1'b0;
        end else if (r_act) begin
            r_rem <= w_fits ? w_diff[31:0] : w_rem_sh[31:0];
            r_quo <= {r_quo[30:0], w_fits};
            r_cnt <= r_cnt + 6'd1;
            if (o_done) begin
                r_act <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/hilo_muldiv.sv
// HI/LO write-port producer: single-cycle MULT/MULTU and MTHI/MTLO,
// multi-cycle DIV/DIVU through the radix-2 core with sign fix-ups.
module hilo_muldiv
    import hilo_muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        cancel_i,
    output logic        busy_o,
    output logic [1:0]  we_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        done_o
);

    state_t r_state;
    state_t w_next;

    logic [1:0]  r_we;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_dbz;
    logic [31:0] r_a_raw;

    logic        w_issue;
    logic        w_is_div;
    logic        w_signed;
    logic        w_div_start;
    logic        w_div_last;
    logic [31:0] w_quo;
    logic [31:0] w_rem;
    logic [31:0] w_div_hi;
    logic [31:0] w_div_lo;
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;

    assign w_issue     = (r_state == ST_IDLE) && start_i && !cancel_i;
    assign w_is_div    = (op_i == OP_DIV) || (op_i == OP_DIVU);
    assign w_signed    = (op_i == OP_DIV);
    assign w_div_start = w_issue && w_is_div;

    // Low 64 bits of a sign-extended product equal the signed product.
    assign w_prod_s = {{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i};
    assign w_prod_u = {32'd0, a_i} * {32'd0, b_i};

    div_radix2_iter u_div (
        .clk         (clk),
        .rst         (rst),
        .i_start     (w_div_start),
        .i_cancel    (cancel_i),
        .i_dividend  (mag32(a_i, w_signed)),
        .i_divisor   (mag32(b_i, w_signed)),
        .o_done      (w_div_last),
        .o_quotient  (w_quo),
        .o_remainder (w_rem)
    );

    // Divide by zero bypasses fix-ups: HI gets the raw dividend.
    assign w_div_lo = (!r_dbz && r_neg_q) ? (~w_quo + 32'd1) : w_quo;
    assign w_div_hi = r_dbz   ? r_a_raw :
                      r_neg_r ? (~w_rem + 32'd1) : w_rem;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: if (w_div_start) w_next = ST_DIV;
            ST_DIV: begin
                if (cancel_i) begin
                    w_next = ST_IDLE;
                end else if (w_div_last) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_o = 1'b0;
        we_o   = 2'b00;
        hi_o   = r_hi;
        lo_o   = r_lo;
        unique case (r_state)
            ST_IDLE: begin
                busy_o = w_div_start;
                we_o   = r_we;
            end
            ST_DIV: busy_o = 1'b1;
            ST_DONE: begin
                we_o = WE_HI | WE_LO;
                hi_o = w_div_hi;
                lo_o = w_div_lo;
            end
            default: ;
        endcase
        if (cancel_i) begin
            we_o = 2'b00;
        end
        done_o = |we_o;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_we    <= 2'b00;
            r_hi    <= '0;
            r_lo    <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_dbz   <= 1'b0;
            r_a_raw <= '0;
        end else begin
            r_we <= 2'b00;
            if (w_issue) begin
                case (op_i)
                    OP_MULT: begin
                        r_we <= WE_HI | WE_LO;
                        r_hi <= w_prod_s[63:32];
                        r_lo <= w_prod_s[31:0];
                    end
                    OP_MULTU: begin
                        r_we <= WE_HI | WE_LO;
                        r_hi <= w_prod_u[63:32];
                        r_lo <= w_prod_u[31:0];
                    end
                    OP_MTHI: begin
                        r_we <= WE_HI;
                        r_hi <= a_i;
                    end
                    OP_MTLO: begin
                        r_we <= WE_LO;
                        r_lo <= a_i;
                    end
                    OP_DIV, OP_DIVU: begin
                        r_neg_q <= w_signed && (a_i[31] ^ b_i[31]);
                        r_neg_r <= w_signed && a_i[31];
                        r_dbz   <= (b_i == 32'd0);
                        r_a_raw <= a_i;
                    end
                    default: ;
                endcase
            end
            if (r_state == ST_DONE && !cancel_i) begin
                r_hi <= w_div_hi;
                r_lo <= w_div_lo;
            end
        end
    end

endmodule

// File: doc/hilo_muldiv.md
Name: hilo_muldiv

Overview:
- Producer side of the HI/LO register write port. Executes MULT/MULTU/DIV/DIVU/MTHI/MTLO issued from EX.
- Drives the HI/LO register's 2-bit write-enable ({hi_we, lo_we}) plus 32-bit hi/lo write data.
- Multiply completes in one cycle. Divide is a 32-iteration radix-2 restoring divider that stalls the pipeline via busy_o.

Parameters:
- DIV_CYCLES, 32, number of divide iterations (fixed at 32 for 32-bit operands; not intended to be overridden)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start_i  in  1  op_i/a_i/b_i valid this cycle
- op_i  in  3  000 NOP, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 reserved (treated as NOP)
- a_i  in  32  rs operand (dividend / multiplicand / MT source)
- b_i  in  32  rt operand (divisor / multiplier)
- cancel_i  in  1  flush (exception); aborts pending/in-flight op
- busy_o  out  1  stall request to pipeline
- we_o  out  2  {hi_we, lo_we} to the HI/LO register
- hi_o  out  32  HI write data
- lo_o  out  32  LO write data
- done_o  out  1  one-cycle completion pulse, equal to |we_o

Behaviour:
- States: IDLE, DIV, DONE.
- Reset: state=IDLE; we_o=00, hi_o=0, lo_o=0, done_o=0, busy_o=0; all iteration registers cleared. Reset mid-divide aborts with no write.
- start_i is sampled only in IDLE; it is ignored in DIV/DONE. The pipeline is stalled then, and the bench must not issue.
- MTHI (start in cycle N): cycle N+1 we_o=10, hi_o=a_i, lo_o unchanged.
- MTLO (start in cycle N): cycle N+1 we_o=01, lo_o=a_i, hi_o unchanged.
- MULT/MULTU (start in cycle N): cycle N+1 we_o=11, {hi_o,lo_o}=64-bit product. MULT uses signed operands; MULTU uses unsigned. busy_o stays 0.
- DIV/DIVU, start cycle N:
  - Cycle N: busy_o=1 (combinational from start_i & divide op). Edge N loads |a|, |b|, sign flags, and the iteration counter=0. State goes to DIV.
  - Cycles N+1..N+32: state=DIV, busy_o=1. One quotient bit is produced per edge, MSB first: shift remainder, subtract divisor, keep the difference if non-negative.
  - After 32 iterations, state goes to DONE.
  - Cycle N+33: state=DONE, we_o=11, busy_o=0, lo_o=quotient, hi_o=remainder. Next cycle returns to IDLE.
  - busy_o is therefore high for exactly 33 cycles (N..N+32).
- Signed fix-ups (DIV only):
  - Quotient is negated if sign(a)^sign(b).
  - Remainder is negated if sign(a); the remainder takes the dividend's sign.
  - Operand absolute values use 32-bit unsigned magnitudes, so 0x80000000 is a magnitude, not an overflow.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0. No trap.
- Divide by zero (b_i==0, DIV or DIVU):
  - Latency is still 33 cycles.
  - Result is hi=a_i (raw), lo=0xFFFFFFFF.
  - Signed fix-ups are bypassed.
- cancel_i:
  - In IDLE with start_i: the op is dropped, busy_o=0 that cycle, and there is no write.
  - In DIV: state goes to IDLE at the next edge, busy_o drops next cycle, and there is no write.
  - In DONE: we_o is forced to 00 that cycle; the write is suppressed.
  - A result registered for MT*/MULT when cancel arrives in cycle N+1 is suppressed the same way.
- Outside completion cycles, we_o=00 and done_o=0. hi_o/lo_o hold their last values.
- Back-to-back: a new start_i is accepted in the cycle after DONE (IDLE) or every cycle for MULT/MT*.

Decomposition:
- Shared package: op_i encodings (OP_NOP..OP_MTLO), state encodings, the WE_HI/WE_LO bit constants matching the HI/LO register's {hi_we, lo_we} order, and DIV_CYCLES.
- One natural sub-module: div_radix2_iter, holding the magnitude registers, 6-bit counter, and per-cycle shift/subtract step. It has start/cancel inputs and done/quotient/remainder outputs.
- Sign handling, MULT, MT*, and output muxing stay in the top level.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=7 at cycle N -> cycle N+1 we_o=11, hi_o=0xFFFFFFFF, lo_o=0xFFFFFFEB, busy_o never 1.
- MULTU a=b=0xFFFFFFFF -> hi_o=0xFFFFFFFE, lo_o=0x00000001. Then MTHI a=0x12345678 next cycle -> we_o=10, hi_o=0x12345678.
- DIVU a=100, b=7 -> busy_o high cycles N..N+32, cycle N+33 we_o=11, lo_o=14, hi_o=2, done_o one cycle.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo_o=0xFFFFFFFD (-3), hi_o=0xFFFFFFFF (-1). DIV 0x80000000/0xFFFFFFFF -> lo_o=0x80000000, hi_o=0.
- DIVU a=0x55, b=0 -> cycle N+33 hi_o=0x55, lo_o=0xFFFFFFFF.
- DIV started, cancel_i at cycle N+10 -> busy_o=0 from N+11, we_o stays 00 through N+40. A following DIVU 9/3 gives lo_o=3, hi_o=0. Repeat with rst at N+10 -> all outputs 0 next cycle.
